// File: rtl/aes_round_ctrl_if.sv
// Handshake and status bundle between the AES round controller and its neighbours.
// The master side drives start/in_valid; the slave side (the controller) drives the rest.
interface aes_round_ctrl_if;
  logic       start;
  logic       in_valid;
  logic       in_ready;
  logic       sr_enable;
  logic [3:0] byte_idx;
  logic [3:0] round;
  logic [7:0] key_addr;
  logic       mix_bypass;
  logic       busy;
  logic       done;

  modport master (
    output start, in_valid,
    input  in_ready, sr_enable, byte_idx, round, key_addr, mix_bypass, busy, done
  );

  modport slave (
    input  start, in_valid,
    output in_ready, sr_enable, byte_idx, round, key_addr, mix_bypass, busy, done
  );
endinterface

// File: rtl/aes_round_ctrl.sv
// AES round sequencer: issues 16 bytes per round for NR rounds, then drains the ShiftRows pipe.
// Optional feature macro: AES_ROUND_CTRL_ABORT_EN adds an abort input that cancels the block.
module aes_round_ctrl #(
  parameter int NR     = 10,
  parameter int SR_LAT = 12
) (
  input  logic            clock,
  input  logic            resetn,
`ifdef AES_ROUND_CTRL_ABORT_EN
  input  logic            abort,
`endif
  aes_round_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  localparam logic [3:0] NR_L       = 4'(NR);
  localparam logic [4:0] DRAIN_INIT = 5'(SR_LAT - 1);

  state_e     state_q, state_d;
  logic [3:0] round_q, round_d;
  logic [3:0] byte_idx_q, byte_idx_d;
  logic [4:0] drain_q, drain_d;
  logic       mix_bypass_q, mix_bypass_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic       abort_s;
  logic       fire_s;

`ifdef AES_ROUND_CTRL_ABORT_EN
  assign abort_s = abort;
`else
  assign abort_s = 1'b0;
`endif

  assign fire_s = (state_q == S_ISSUE) && bus.in_valid;

  // Next-state and counter logic; abort outranks a simultaneous byte fire.
  always_comb begin
    state_d    = state_q;
    round_d    = round_q;
    byte_idx_d = byte_idx_q;
    drain_d    = drain_q;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          state_d    = S_ISSUE;
          round_d    = 4'd1;
          byte_idx_d = 4'd0;
        end else begin
          state_d    = S_IDLE;
        end
      end
      S_ISSUE: begin
        if (abort_s) begin
          state_d    = S_IDLE;
          round_d    = 4'd0;
          byte_idx_d = 4'd0;
          drain_d    = 5'd0;
        end else if (fire_s) begin
          if (byte_idx_q == 4'd15) begin
            byte_idx_d = 4'd0;
            if (round_q == NR_L) begin
              state_d = S_DRAIN;
              drain_d = DRAIN_INIT;
            end else begin
              round_d = round_q + 4'd1;
            end
          end else begin
            byte_idx_d = byte_idx_q + 4'd1;
          end
        end else begin
          state_d = S_ISSUE;
        end
      end
      S_DRAIN: begin
        if (abort_s) begin
          state_d    = S_IDLE;
          round_d    = 4'd0;
          byte_idx_d = 4'd0;
          drain_d    = 5'd0;
        end else if (drain_q == 5'd0) begin
          state_d = S_DONE;
        end else begin
          drain_d = drain_q - 5'd1;
        end
      end
      S_DONE: begin
        state_d    = S_IDLE;
        round_d    = 4'd0;
        byte_idx_d = 4'd0;
        drain_d    = 5'd0;
      end
      default: begin
        state_d    = S_IDLE;
        round_d    = 4'd0;
        byte_idx_d = 4'd0;
        drain_d    = 5'd0;
      end
    endcase
    mix_bypass_d = (round_d == NR_L);
    busy_d       = (state_d != S_IDLE);
    done_d       = (state_d == S_DONE);
  end

  // State and registered status flops.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q      <= S_IDLE;
      round_q      <= 4'd0;
      byte_idx_q   <= 4'd0;
      drain_q      <= 5'd0;
      mix_bypass_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      round_q      <= round_d;
      byte_idx_q   <= byte_idx_d;
      drain_q      <= drain_d;
      mix_bypass_q <= mix_bypass_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

  assign bus.in_ready   = (state_q == S_ISSUE);
  assign bus.sr_enable  = fire_s || (state_q == S_DRAIN);
  assign bus.byte_idx   = byte_idx_q;
  assign bus.round      = round_q;
  assign bus.key_addr   = {round_q, byte_idx_q};
  assign bus.mix_bypass = mix_bypass_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;

endmodule

// File: tb/tb_aes_round_ctrl.sv
// Directed bench for aes_round_ctrl: a vector table for the default block plus
// hand-written latency, stall, reset, back-to-back and small-parameter sequences.
module tb_aes_round_ctrl;
  logic clock;
  logic resetn;
  int   n_chk;
  int   n_pass;

  aes_round_ctrl_if b0 ();
  aes_round_ctrl_if b1 ();
`ifdef AES_ROUND_CTRL_ABORT_EN
  logic abort0;
  logic abort1;
`endif

  aes_round_ctrl u0 (
    .clock (clock),
    .resetn(resetn),
`ifdef AES_ROUND_CTRL_ABORT_EN
    .abort (abort0),
`endif
    .bus   (b0)
  );

  aes_round_ctrl #(.NR(1), .SR_LAT(1)) u1 (
    .clock (clock),
    .resetn(resetn),
`ifdef AES_ROUND_CTRL_ABORT_EN
    .abort (abort1),
`endif
    .bus   (b1)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1);
  end

  typedef struct {
    int         adv;
    logic       st;
    logic       iv;
    logic [3:0] rnd;
    logic [3:0] bidx;
    logic       busy;
    logic       done;
    logic       mix;
    logic       rdy;
    logic       sre;
    logic [7:0] ka;
  } vec_t;

  vec_t vecs [13];

  task automatic check(input string nm, input longint act, input longint exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h want 0x%0h", nm, act, exp);
  endtask

  function automatic logic [20:0] obs0();
    return {b0.round, b0.byte_idx, b0.busy, b0.done, b0.mix_bypass,
            b0.in_ready, b0.sr_enable, b0.key_addr};
  endfunction

  function automatic logic [20:0] pk(input vec_t v);
    return {v.rnd, v.bidx, v.busy, v.done, v.mix, v.rdy, v.sre, v.ka};
  endfunction

  // Starts a block on u0 from IDLE and runs until done or the cycle bound.
  task automatic run_block(input bit alt, input bit hold, output int k,
                           output int sre_n, output int mix_n, output int hold_err);
    logic [3:0] pr;
    logic [3:0] pb;
    logic       pv;
    k = 0; sre_n = 0; mix_n = 0; hold_err = 0;
    pv = 1'b0; pr = 4'd0; pb = 4'd0;
    b0.start = 1'b1;
    b0.in_valid = 1'b1;
    while (k < 2000) begin
      @(posedge clock);
      @(negedge clock);
      k++;
      b0.start = hold;
      b0.in_valid = alt ? (k % 2 == 0) : 1'b1;
      #1;
      if (pv && (b0.round != pr || b0.byte_idx != pb)) hold_err++;
      pv = b0.in_ready && !b0.in_valid;
      pr = b0.round;
      pb = b0.byte_idx;
      if (b0.sr_enable) sre_n++;
      if (b0.mix_bypass && b0.in_ready && b0.in_valid) mix_n++;
      if (b0.done) break;
    end
    @(posedge clock);
    @(negedge clock);
    b0.start = hold;
    b0.in_valid = 1'b1;
    #1;
  endtask

  task automatic do_reset();
    @(negedge clock);
    resetn = 1'b0;
    b0.start = 1'b0;
    b1.start = 1'b0;
    repeat (2) @(negedge clock);
    resetn = 1'b1;
  endtask

  initial begin
    int k, sre_n, mix_n, hold_err, done_seen, ka_err, ka_n;
    n_chk = 0;
    n_pass = 0;
    resetn = 1'b0;
    b0.start = 1'b0; b0.in_valid = 1'b0;
    b1.start = 1'b0; b1.in_valid = 1'b0;
`ifdef AES_ROUND_CTRL_ABORT_EN
    abort0 = 1'b0; abort1 = 1'b0;
`endif

    //            adv  st    iv    rnd    bidx    busy  done  mix   rdy   sre   ka
    vecs[0]  = '{0,   1'b0, 1'b1, 4'd0,  4'd0,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00};
    vecs[1]  = '{1,   1'b1, 1'b1, 4'd1,  4'd0,  1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 8'h10};
    vecs[2]  = '{5,   1'b0, 1'b1, 4'd1,  4'd5,  1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 8'h15};
    vecs[3]  = '{3,   1'b0, 1'b0, 4'd1,  4'd5,  1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'h15};
    vecs[4]  = '{10,  1'b0, 1'b1, 4'd1,  4'd15, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 8'h1F};
    vecs[5]  = '{1,   1'b0, 1'b1, 4'd2,  4'd0,  1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 8'h20};
    vecs[6]  = '{128, 1'b0, 1'b1, 4'd10, 4'd0,  1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 8'hA0};
    vecs[7]  = '{15,  1'b0, 1'b1, 4'd10, 4'd15, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 8'hAF};
    vecs[8]  = '{1,   1'b0, 1'b1, 4'd10, 4'd0,  1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 8'hA0};
    vecs[9]  = '{11,  1'b0, 1'b1, 4'd10, 4'd0,  1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 8'hA0};
    vecs[10] = '{1,   1'b1, 1'b1, 4'd10, 4'd0,  1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'hA0};
    vecs[11] = '{1,   1'b1, 1'b1, 4'd0,  4'd0,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00};
    vecs[12] = '{1,   1'b0, 1'b1, 4'd0,  4'd0,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00};

    repeat (3) @(negedge clock);
    resetn = 1'b1;

    for (int i = 0; i < 13; i++) begin
      b0.start = vecs[i].st;
      b0.in_valid = vecs[i].iv;
      if (vecs[i].adv > 0) begin
        repeat (vecs[i].adv) @(posedge clock);
        @(negedge clock);
      end
      #1;
      check($sformatf("vec%0d {rnd,bidx,busy,done,mix,rdy,sre,ka}", i), obs0(), pk(vecs[i]));
    end

    // Full block, in_valid held high.
    run_block(1'b0, 1'b0, k, sre_n, mix_n, hold_err);
    check("latency_cycles", k, 173);
    check("sre_pulses", sre_n, 172);
    check("mix_issue_cycles", mix_n, 16);

    // in_valid low on every other issue cycle.
    run_block(1'b1, 1'b0, k, sre_n, mix_n, hold_err);
    check("stall_latency", k, 333);
    check("stall_sre_pulses", sre_n, 172);
    check("stall_hold_errors", hold_err, 0);
    check("stall_mix_fires", mix_n, 16);

    // start held high: one IDLE cycle between done and the next round 1.
    run_block(1'b0, 1'b1, k, sre_n, mix_n, hold_err);
    check("b2b_latency", k, 173);
    check("b2b_idle_gap {busy,round}", {b0.busy, b0.round}, {1'b0, 4'd0});
    @(posedge clock);
    @(negedge clock);
    #1;
    check("b2b_restart {busy,round}", {b0.busy, b0.round}, {1'b1, 4'd1});
    do_reset();

    // Reset asserted at round 4, byte 7.
    b0.start = 1'b1;
    b0.in_valid = 1'b1;
    repeat (56) begin
      @(posedge clock);
      @(negedge clock);
      b0.start = 1'b0;
    end
    #1;
    check("pre_reset {round,bidx}", {b0.round, b0.byte_idx}, {4'd4, 4'd7});
    resetn = 1'b0;
    #1;
    check("async_reset {busy,round,bidx,rdy,sre,mix,done}",
          {b0.busy, b0.round, b0.byte_idx, b0.in_ready, b0.sr_enable, b0.mix_bypass, b0.done},
          {1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0});
    done_seen = 0;
    repeat (3) begin
      @(negedge clock);
      if (b0.done) done_seen++;
    end
    check("reset_no_done", done_seen, 0);
    resetn = 1'b1;
    run_block(1'b0, 1'b0, k, sre_n, mix_n, hold_err);
    check("post_reset_latency", k, 173);

    // Small configuration: NR=1, SR_LAT=1.
    b1.start = 1'b1;
    b1.in_valid = 1'b1;
    k = 0; ka_err = 0; ka_n = 0;
    while (k < 100) begin
      @(posedge clock);
      @(negedge clock);
      k++;
      b1.start = 1'b0;
      #1;
      if (k == 1) check("nr1_mix_at_cycle1", b1.mix_bypass, 1'b1);
      if (b1.in_ready) begin
        ka_n++;
        if (b1.key_addr != 8'(8'h10 + k - 1)) ka_err++;
      end
      if (b1.done) break;
    end
    check("nr1_latency", k, 18);
    check("nr1_key_addr_errors", ka_err, 0);
    check("nr1_issue_cycles", ka_n, 16);

`ifdef AES_ROUND_CTRL_ABORT_EN
    // Abort coinciding with the byte-15 fire of round 3.
    @(negedge clock);
    b0.start = 1'b1;
    b0.in_valid = 1'b1;
    repeat (48) begin
      @(posedge clock);
      @(negedge clock);
      b0.start = 1'b0;
    end
    #1;
    check("pre_abort {round,bidx}", {b0.round, b0.byte_idx}, {4'd3, 4'd15});
    abort0 = 1'b1;
    @(posedge clock);
    @(negedge clock);
    abort0 = 1'b0;
    #1;
    check("abort {busy,round,bidx,done}", {b0.busy, b0.round, b0.byte_idx, b0.done},
          {1'b0, 4'd0, 4'd0, 1'b0});
    done_seen = 0;
    repeat (200) begin
      @(negedge clock);
      if (b0.done) done_seen++;
    end
    check("abort_no_done", done_seen, 0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
